mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store initiator for the MIPS MEM stage.
- Turns pipeline byte-addressed load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw) into read/write strobes on the word-indexed data memory.
- Sub-word stores are done as read-modify-write, because the memory supports whole-word writes only.
- Sits between the MEM-stage pipeline register and data_mem; drives pipeline stall through busy.

Parameters:
- ADDR_BITS, 10, number of word-index bits driven on mem_address (memory depth 2^ADDR_BITS words); upper index bits are zero.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present; held stable by pipeline until resp_valid
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  `WORD  byte address
- req_wdata  input  `WORD  store data, right-justified
- resp_valid  output  1  one-cycle pulse: request complete
- resp_err  output  1  valid with resp_valid: illegal size or misaligned (see option)
- load_data  output  `WORD  extended load result; valid with resp_valid, held until next response
- busy  output  1  state != IDLE
- mem_read  output  1  read strobe to data memory
- mem_write  output  1  write strobe to data memory
- mem_address  output  `WORD  word index = {zeros, req_addr[ADDR_BITS+1:2]}
- mem_write_data  output  `WORD  full word to write
- mem_read_data  input  `WORD  memory read word; valid in the same cycle mem_read is high

Behaviour:
- Reset: state IDLE; resp_valid, resp_err, busy, mem_read, mem_write are 0; mem_address, mem_write_data, load_data are 0.
- Reset is asynchronous and aborts any operation. No strobe is asserted after reset. A store aborted before the WR state leaves memory untouched.
- Request latch: on the edge where state is IDLE and req_valid=1, capture all req_* fields into internal registers. The request is not re-sampled until the next IDLE.
- Little-endian byte lanes: offset 0 = bits[7:0], offset 3 = bits[31:24]. Half at offset 0 = [15:0], half at offset 2 = [31:16].
- States: IDLE, RD, MERGE, WR, RESP.
- IDLE to RD: load, or sub-word store.
- IDLE to WR: word store.
- IDLE to RESP: error request; resp_err=1 and no memory strobe is issued.
- RD: mem_read=1 and mem_address is driven. At the end of RD, register mem_read_data. Load goes to RESP; sub-word store goes to MERGE.
- MERGE: replace the addressed byte/half lane of the registered word with req_wdata[7:0] or [15:0]; other lanes are unchanged. Go to WR. No strobes in this state.
- WR: mem_write=1 for exactly one cycle, with mem_address and mem_write_data stable. Go to RESP.
- RESP: resp_valid=1 for one cycle; load_data updated for loads (unchanged for stores); go to IDLE.
- A new request can be accepted on the edge after RESP (i.e., in the following IDLE cycle).
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - load: 2 cycles
  - sw: 2 cycles
  - sb/sh: 4 cycles
  - error: 1 cycle
- mem_read and mem_write are never high together. mem_write_data is 0 outside WR.
- Load extraction: select the lane, then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1). Word loads ignore req_unsigned.
- Illegal size 11 always produces an error response with no memory access.
- Address bits above ADDR_BITS+1 are ignored (memory wrap-around).
- req_valid dropping mid-operation is a protocol violation; the latched request completes regardless.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: half access with addr[0]!=0, or word access with addr[1:0]!=0, goes IDLE to RESP with resp_err=1. No strobes; load_data unchanged.
- Undefined: misaligned low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=00). The access then proceeds normally with resp_err=0.

Test Plan:
- Word at 0x10 = 0x8899AABB. lw addr 0x10 -> mem_read high 1 cycle with mem_address=4; resp_valid 2 cycles after accept; load_data=0x8899AABB.
- Same word. lb addr 0x12 -> 0xFFFFFF99. lbu addr 0x12 -> 0x00000099. lh addr 0x12 -> 0xFFFF8899. lhu addr 0x10 -> 0x0000AABB.
- Word at 0x20 = 0x11223344. sb addr 0x21, wdata 0xDEADBEEF -> RD, MERGE, WR sequence; one mem_write with mem_write_data=0x1122EF44; resp 4 cycles after accept. Then sh addr 0x22, wdata 0x5566 -> word becomes 0x5566EF44.
- req_size=11 -> resp_valid and resp_err 1 cycle after accept; mem_read and mem_write never asserted. With MISALIGN_TRAP_EN: lw addr 0x13 -> same error response. Without it: lw addr 0x13 returns the word at 0x10.
- Assert reset during the MERGE cycle of sb addr 0x21 -> all outputs 0 immediately; no mem_write ever seen; memory word still 0x11223344; a following lw addr 0x20 completes normally.
- Back-to-back: sw 0x30 then lw 0x30 with req_valid held -> second request accepted in the IDLE cycle after the first resp_valid; load_data equals the stored value.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw onto a word-only data memory.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err instead of being force-aligned.
module mem_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  state_dbg
);

  // Handshake: the request is sampled only on an edge where state is IDLE and
  // req_valid=1; fields must stay stable until resp_valid, which pulses for one cycle.

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t                 state, state_d;
  logic                   write_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [1:0]             off_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [15:0]            wdata_q;
  logic                   err_q;
  logic [31:0]            word_q;

  logic                   req_err;
  logic [1:0]             req_off;
  logic [31:0]            merged;
  logic [31:0]            extracted;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_BITS+2];

  always_comb begin
    req_err = (req_size == 2'b11);
    req_off = req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`else
    if (req_size == 2'b01) req_off[0] = 1'b0;
    if (req_size == 2'b10) req_off    = 2'b00;
`endif
  end

  always_comb begin
    lane_b = mem_read_data[{off_q, 3'b000} +: 8];
    lane_h = mem_read_data[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   extracted = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   extracted = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: extracted = mem_read_data;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                 merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err)                             state_d = RESP;
        else if (req_write && req_size == 2'b10) state_d = WR;
        else                                     state_d = RD;
      end
      RD:      state_d = write_q ? MERGE : RESP;
      MERGE:   state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= 16'h0;
      err_q     <= 1'b0;
      word_q    <= 32'h0;
      load_data <= 32'h0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (req_valid) begin
          write_q <= req_write;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          off_q   <= req_off;
          idx_q   <= req_addr[ADDR_BITS+1:2];
          wdata_q <= req_wdata[15:0];
          err_q   <= req_err;
          word_q  <= req_wdata;
        end
        RD: begin
          word_q <= mem_read_data;
          if (!write_q) load_data <= extracted;
        end
        MERGE:   word_q <= merged;
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign mem_read       = (state == RD);
  assign mem_write      = (state == WR);
  assign mem_write_data = (state == WR) ? word_q : 32'h0;
  assign mem_address    = {{(32-ADDR_BITS){1'b0}}, idx_q};
  assign resp_valid     = (state == RESP);
  assign resp_err       = (state == RESP) && err_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed steps plus randomized requests scored
// against a byte-lane arithmetic reference model and a shadow memory image.
module tb_mem_access_unit;
  localparam int AB = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy, mem_read, mem_write;
  logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, wr_cnt = 0, bad_cnt = 0;
  int last_wait = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] exp_ld = 32'h0;
  logic [31:0] mem     [0:(1<<AB)-1];
  logic [31:0] ref_mem [0:(1<<AB)-1];
  logic [31:0] exp_q[$];

  mem_access_unit #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .load_data(load_data), .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .state_dbg(state_dbg)
  );

  // clock / memory / monitor
  always #5 clk = ~clk;

  assign mem_read_data = mem_read ? mem[mem_address[AB-1:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[AB-1:0]] <= mem_write_data;
  end

  always @(posedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wdata = mem_write_data;
    end
    if (mem_read && mem_write) bad_cnt++;
    if (!mem_write && mem_write_data !== 32'h0) bad_cnt++;
    if (mem_address[31:AB] !== '0) bad_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: lane arithmetic on a plain word array.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int idx, off, sh, exp_lat, exp_rd, exp_wr, lat, guard, r0, w0;
    bit err, got;
    logic [31:0] word, v, mask;
    idx = int'((addr >> 2) % (1 << AB));
    off = int'(addr % 4);
    err = (sz == 2'd3);
`ifdef MISALIGN_TRAP_EN
    if ((sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0)) err = 1;
`else
    if (sz == 2'd1) off = off - off % 2;
    if (sz == 2'd2) off = 0;
`endif
    sh = 8 * off;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_lat = err ? 1 : (w && sz != 2'd2) ? 4 : 2;
    exp_rd  = (!err && !(w && sz == 2'd2)) ? 1 : 0;
    exp_wr  = (!err && w) ? 1 : 0;
    word = ref_mem[idx];
    if (!err && !w) begin
      v = (word >> sh) & mask;
      if (!uns && sz == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
      if (!uns && sz == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      exp_ld = v;
    end
    if (!err && w) ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    exp_q.push_back(exp_ld);

    req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    last_wait = guard;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 8) begin
      #1;
      lat++;
      if (resp_valid === 1'b1) got = 1;
      else @(posedge clk);
    end
    if (!hold) req_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", {31'b0, resp_err}, {31'b0, err});
    check("load_data", load_data, exp_q.pop_front());
    check("read_strobes", 32'(rd_cnt - r0), 32'(exp_rd));
    check("write_strobes", 32'(wr_cnt - w0), 32'(exp_wr));
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  function automatic logic [31:0] outs_vec();
    return {resp_valid, resp_err, busy, mem_read, mem_write, 27'b0}
           | load_data | mem_address | mem_write_data;
  endfunction

  initial begin
    int w0, diffs;
    logic [1:0] sz;
    logic [31:0] a;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < (1 << AB); i++) preload(i, $urandom());
    #1;
    check("reset_outputs", outs_vec(), 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // loads from the reference word
    preload(4, 32'h8899AABB);
    run_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    check("lw_const", load_data, 32'h8899AABB);
    run_req(0, 2'd0, 0, 32'h12, 32'h0, 0);
    check("lb_const", load_data, 32'hFFFFFF99);
    run_req(0, 2'd0, 1, 32'h12, 32'h0, 0);
    check("lbu_const", load_data, 32'h00000099);
    run_req(0, 2'd1, 0, 32'h12, 32'h0, 0);
    check("lh_const", load_data, 32'hFFFF8899);
    run_req(0, 2'd1, 1, 32'h10, 32'h0, 0);
    check("lhu_const", load_data, 32'h0000AABB);

    // sub-word stores by read-modify-write
    preload(8, 32'h11223344);
    run_req(1, 2'd0, 0, 32'h21, 32'hDEADBEEF, 0);
    check("sb_wdata", last_wdata, 32'h1122EF44);
    check("sb_mem", mem[8], 32'h1122EF44);
    run_req(1, 2'd1, 0, 32'h22, 32'h00005566, 0);
    check("sh_mem", mem[8], 32'h5566EF44);

    // illegal size and misaligned word
    run_req(0, 2'd3, 0, 32'h10, 32'h0, 0);
    run_req(1, 2'd3, 0, 32'h10, 32'hFFFFFFFF, 0);
    run_req(0, 2'd2, 0, 32'h13, 32'h0, 0);
`ifndef MISALIGN_TRAP_EN
    check("lw_misaligned", load_data, 32'h8899AABB);
`endif

    // reset during MERGE of sb 0x21
    preload(8, 32'h11223344);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    w0 = wr_cnt;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_outputs", outs_vec(), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_ld = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_write", 32'(wr_cnt - w0), 32'h0);
    check("abort_mem", mem[8], 32'h11223344);
    run_req(0, 2'd2, 0, 32'h20, 32'h0, 0);
    check("after_abort_lw", load_data, 32'h11223344);

    // back-to-back with req_valid held
    run_req(1, 2'd2, 0, 32'h30, 32'hCAFEF00D, 1);
    run_req(0, 2'd2, 0, 32'h30, 32'h0, 0);
    check("b2b_gap", 32'(last_wait), 32'd1);
    check("b2b_data", load_data, 32'hCAFEF00D);

    // randomized traffic, upper address bits exercise wrap-around
    for (int n = 0; n < 200; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
              bit'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    diffs = 0;
    for (int i = 0; i < (1 << AB); i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 32'(diffs), 32'h0);
    check("strobe_rules", 32'(bad_cnt), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
